// File: rtl/cnn_pkg.sv
// Shared types and constants for the classifier back end.
// Used by the FC sequencer and its feature buffer.
package cnn_pkg;

    localparam int LANES      = 16;
    localparam int BEATS      = 4;
    localparam int FEAT_W     = 8;
    localparam int FC_IN      = 4;
    localparam int FC_TIMEOUT = 1023;

    localparam int DEPTH  = LANES * BEATS;
    localparam int GROUPS = DEPTH / FC_IN;

    localparam int WR_W   = 3;
    localparam int RD_W   = 4;
    localparam int TMO_W  = $clog2(FC_TIMEOUT + 1);
    localparam int ROW_W  = $clog2(BEATS);
    localparam int GRP_W  = $clog2(GROUPS);
    localparam int LANE_W = $clog2(LANES);
    localparam int ELEM_W = $clog2(FC_IN);

    typedef logic signed [FEAT_W-1:0] feat_t;
    typedef logic [1:0] class_t;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        FEED,
        WAIT_FC,
        RESULT
    } fc_seq_state_t;

endpackage

// File: rtl/feat_buffer.sv
// 64-entry feature store: a full row of lanes is written per beat,
// a group of FC_IN features is read per FC cycle.
module feat_buffer
    import cnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [ROW_W-1:0]        wr_row_i,
    input  logic [LANES*FEAT_W-1:0] wr_data_i,
    input  logic [GRP_W-1:0]        rd_grp_i,
    output logic [FC_IN*FEAT_W-1:0] rd_data_o
);

    feat_t mem_q [DEPTH];

    // Row write: lane k lands at row*LANES + k; contents are never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < LANES; k++) begin
                mem_q[{wr_row_i, LANE_W'(k)}] <= wr_data_i[k*FEAT_W +: FEAT_W];
            end
        end
    end

    // Group read: element j comes from grp*FC_IN + j.
    always_comb begin
        rd_data_o = '0;
        for (int j = 0; j < FC_IN; j++) begin
            rd_data_o[j*FEAT_W +: FEAT_W] = mem_q[{rd_grp_i, ELEM_W'(j)}];
        end
    end

endmodule

// File: rtl/fc_sequencer.sv
// Classifier back-end sequencer: conv kick-off, feature collection,
// FC streaming, FC completion wait with timeout, and result hold.
module fc_sequencer
    import cnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    conv_start,
    input  logic                    feat_valid,
    input  logic [LANES*FEAT_W-1:0] feat_data,
    input  logic                    layer_done,
    output logic                    fc_en,
    output logic [FC_IN*FEAT_W-1:0] fc_in,
    input  logic                    fc_done,
    input  class_t                  fc_class,
    output logic                    busy,
    output logic                    result_valid,
    output class_t                  result_class,
    output logic [7:0]              seg,
    output logic                    error
);

    localparam logic [WR_W-1:0]  BEATS_C = WR_W'(BEATS);
    localparam logic [RD_W-1:0]  RD_LAST = RD_W'(GROUPS - 1);
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(FC_TIMEOUT - 1);

    fc_seq_state_t state_q, state_d;
    logic [WR_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             error_q, error_d;
    logic             conv_q, conv_d;
    logic             fc_en_q, fc_en_d;
    logic             rv_q, rv_d;
    logic             busy_q;
    class_t           cls_q, cls_d;
    logic [FC_IN*FEAT_W-1:0] fc_in_q, fc_in_d;
    logic [FC_IN*FEAT_W-1:0] rd_data;
    logic             we;

    feat_buffer u_buf (
        .clk       (clk),
        .we_i      (we),
        .wr_row_i  (wr_cnt_q[ROW_W-1:0]),
        .wr_data_i (feat_data),
        .rd_grp_i  (rd_cnt_d),
        .rd_data_o (rd_data)
    );

    // Next state, counters and next output values.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        tmo_d    = tmo_q;
        error_d  = error_q;
        cls_d    = cls_q;
        conv_d   = 1'b0;
        fc_en_d  = 1'b0;
        rv_d     = 1'b0;
        we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = COLLECT;
                    wr_cnt_d = '0;
                    error_d  = 1'b0;
                    conv_d   = 1'b1;
                end
            end
            COLLECT: begin
                if (feat_valid) begin
                    if (wr_cnt_q < BEATS_C) begin
                        we       = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                if (layer_done) begin
                    if (wr_cnt_d == BEATS_C) begin
                        state_d  = FEED;
                        rd_cnt_d = '0;
                        fc_en_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d = WAIT_FC;
                    tmo_d   = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    fc_en_d  = 1'b1;
                end
            end
            WAIT_FC: begin
                if (fc_done) begin
                    state_d = RESULT;
                    cls_d   = fc_class;
                    rv_d    = 1'b1;
                end else if (tmo_q == TMO_END) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        fc_in_d = fc_en_d ? rd_data : fc_in_q;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            tmo_q    <= '0;
            error_q  <= 1'b0;
            cls_q    <= '0;
            conv_q   <= 1'b0;
            fc_en_q  <= 1'b0;
            rv_q     <= 1'b0;
            busy_q   <= 1'b0;
            fc_in_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            tmo_q    <= tmo_d;
            error_q  <= error_d;
            cls_q    <= cls_d;
            conv_q   <= conv_d;
            fc_en_q  <= fc_en_d;
            rv_q     <= rv_d;
            busy_q   <= (state_d != IDLE);
            fc_in_q  <= fc_in_d;
        end
    end

    assign conv_start   = conv_q;
    assign fc_en        = fc_en_q;
    assign fc_in        = fc_in_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign result_class = cls_q;
    assign seg          = {6'b0, cls_q};
    assign error        = error_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Scoreboard bench for fc_sequencer: directed runs push expected
// fc_in groups and classes; a monitor pops them as the DUT emits.
module tb_fc_sequencer;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst, start, feat_valid, layer_done, fc_done;
    logic [LANES*FEAT_W-1:0] feat_data;
    logic [FC_IN*FEAT_W-1:0] fc_in;
    logic [1:0] fc_class, result_class;
    logic [7:0] seg;
    logic conv_start, fc_en, busy, result_valid, error;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_fc [$];
    logic [1:0]  exp_cls [$];

    fc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .conv_start   (conv_start),
        .feat_valid   (feat_valid),
        .feat_data    (feat_data),
        .layer_done   (layer_done),
        .fc_en        (fc_en),
        .fc_in        (fc_in),
        .fc_done      (fc_done),
        .fc_class     (fc_class),
        .busy         (busy),
        .result_valid (result_valid),
        .result_class (result_class),
        .seg          (seg),
        .error        (error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fbyte(int mult, int off, int idx);
        return 8'(mult * idx + off);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents data.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [1:0]  c;
        if (rst === 1'b0) begin
            if (fc_en === 1'b1) begin
                checks++;
                if (exp_fc.size() == 0) begin
                    errors++;
                    $display("FAIL fc_in: unexpected fc_en, got %h", fc_in);
                end else begin
                    e = exp_fc.pop_front();
                    if (fc_in !== e) begin
                        errors++;
                        $display("FAIL fc_in: got %h expected %h", fc_in, e);
                    end
                end
            end
            if (result_valid === 1'b1) begin
                checks++;
                if (exp_cls.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected pulse, class %0d", result_class);
                end else begin
                    c = exp_cls.pop_front();
                    if (result_class !== c) begin
                        errors++;
                        $display("FAIL result_class: got %0d expected %0d", result_class, c);
                    end
                end
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("conv_start_pulse", conv_start, 1);
        chk("busy_after_start", busy, 1);
        chk("error_cleared", error, 0);
        @(negedge clk);
        chk("conv_start_drop", conv_start, 0);
    endtask

    task automatic beat(int mult, int off, int b, bit with_ld);
        for (int k = 0; k < LANES; k++)
            feat_data[k*FEAT_W +: FEAT_W] = fbyte(mult, off, b * LANES + k);
        feat_valid = 1'b1;
        layer_done = with_ld;
        @(negedge clk);
        feat_valid = 1'b0;
        layer_done = 1'b0;
    endtask

    task automatic push_feed(int mult, int off);
        for (int n = 0; n < GROUPS; n++)
            exp_fc.push_back({fbyte(mult, off, 4*n+3), fbyte(mult, off, 4*n+2),
                              fbyte(mult, off, 4*n+1), fbyte(mult, off, 4*n)});
    endtask

    task automatic pulse_ld();
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
    endtask

    task automatic feed(int inject);
        int hi = 0;
        for (int i = 0; i < GROUPS; i++) begin
            if (fc_en === 1'b1) hi++;
            if (i == inject) begin
                start   = 1'b1;
                fc_done = 1'b1;
            end
            @(negedge clk);
            start   = 1'b0;
            fc_done = 1'b0;
            if (i == inject) chk("start_ignored", conv_start, 0);
        end
        chk("fc_en_run_len", hi, GROUPS);
        chk("fc_en_end", fc_en, 0);
    endtask

    task automatic finish_fc(logic [1:0] cls, bit exp_err);
        repeat (3) @(negedge clk);
        fc_done  = 1'b1;
        fc_class = cls;
        exp_cls.push_back(cls);
        @(negedge clk);
        fc_done  = 1'b0;
        chk("result_valid", result_valid, 1);
        chk("seg", seg, {6'b0, cls});
        chk("error_at_result", error, exp_err);
        @(negedge clk);
        chk("result_valid_drop", result_valid, 0);
        chk("busy_after_result", busy, 0);
    endtask

    task automatic full_run(int mult, int off, logic [1:0] cls);
        start_run();
        push_feed(mult, off);
        for (int b = 0; b < BEATS; b++) beat(mult, off, b, 1'b0);
        pulse_ld();
        feed(-1);
        finish_fc(cls, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        feat_valid = 1'b0;
        layer_done = 1'b0;
        fc_done = 1'b0;
        fc_class = 2'd0;
        feat_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs",
            {conv_start, fc_en, busy, result_valid, error, result_class, seg},
            0);
        chk("rst_fc_in", fc_in, 0);

        // Nominal: byte = index, class 1.
        full_run(1, 0, 2'd1);

        // Early layer_done after 3 beats, then a clean run.
        start_run();
        for (int b = 0; b < 3; b++) beat(1, 0, b, 1'b0);
        pulse_ld();
        chk("early_busy", busy, 0);
        chk("early_error", error, 1);
        full_run(3, 7, 2'd2);

        // Overflow: fifth beat is dropped.
        start_run();
        push_feed(5, 9);
        for (int b = 0; b < BEATS; b++) beat(5, 9, b, 1'b0);
        beat(0, 8'hEE, 0, 1'b0);
        chk("ovf_error", error, 1);
        chk("ovf_busy", busy, 1);
        pulse_ld();
        feed(-1);
        finish_fc(2'd3, 1'b1);

        // Collisions: last beat with layer_done; start and fc_done in FEED.
        start_run();
        push_feed(7, 3);
        for (int b = 0; b < BEATS; b++) beat(7, 3, b, b == BEATS - 1);
        feed(5);
        finish_fc(2'd2, 1'b0);

        // Timeout: no fc_done.
        start_run();
        push_feed(2, 1);
        for (int b = 0; b < BEATS; b++) beat(2, 1, b, 1'b0);
        pulse_ld();
        feed(-1);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", n, FC_TIMEOUT);
        chk("tmo_error", error, 1);
        chk("tmo_seg_held", seg, 8'h02);

        // Reset mid-FEED, then a full run.
        start_run();
        push_feed(1, 0);
        for (int b = 0; b < BEATS; b++) beat(1, 0, b, 1'b0);
        pulse_ld();
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_fc_en", fc_en, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_fc.delete();
        @(negedge clk);
        chk("rst_seg", seg, 0);
        full_run(11, 5, 2'd1);

        chk("fc_q_empty", exp_fc.size(), 0);
        chk("cls_q_empty", exp_cls.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_sequencer.md
Name: fc_sequencer

Overview:
- Sequences the classifier back end: on start, pulses the conv layers, collects the flattened layer-4 feature map from 16 parallel max-pool lanes into a local 64-byte buffer, streams it to the fully-connected datapath 4 bytes per cycle, waits for fc_done, then latches and presents the class.
- Sits between the layer-4 max-pool outputs and the fullyconnected datapath, under top-level control.

Parameters:
- LANES, 16, parallel layer-4 output lanes written per feat_valid beat
- BEATS, 4, feat_valid beats per inference (buffer depth = LANES*BEATS = 64 bytes)
- FEAT_W, 8, signed feature width in bits
- FC_IN, 4, features delivered to the FC per fc_en cycle
- FC_TIMEOUT, 1023, maximum cycles in WAIT_FC before error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  inference request; sampled only in IDLE
- conv_start  out  1  one-cycle pulse to conv layers 1-4 on accepted start
- feat_valid  in  1  max-pool output beat valid (maxflag)
- feat_data  in  LANES*FEAT_W  lane k in bits [k*FEAT_W +: FEAT_W]
- layer_done  in  1  layer 4 finished (done4)
- fc_en  out  1  FC input valid
- fc_in  out  FC_IN*FEAT_W  element j in bits [j*FEAT_W +: FEAT_W]
- fc_done  in  1  FC finished
- fc_class  in  2  FC class output, valid with fc_done
- busy  out  1  high in any state except IDLE
- result_valid  out  1  one-cycle pulse when result_class/seg update
- result_class  out  2  last class, held
- seg  out  8  display code {6'b0, result_class}, held
- error  out  1  sticky; cleared on the next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Buffer contents are not reset.
- All outputs are registered.
- States: IDLE -> COLLECT -> FEED -> WAIT_FC -> RESULT -> IDLE.
- IDLE: on start=1:
  - go to COLLECT, wr_cnt=0, error=0
  - conv_start=1 for exactly the next cycle
- COLLECT, feat_valid=1 and wr_cnt<BEATS:
  - buf[wr_cnt*LANES+k] <= lane k, k=0..15
  - wr_cnt++
- COLLECT, feat_valid=1 and wr_cnt==BEATS: beat dropped, error=1, stay in COLLECT.
- COLLECT, layer_done=1: evaluated using the count including any same-cycle write.
  - count==BEATS -> FEED, rd_cnt=0
  - otherwise -> IDLE with error=1
- Simultaneous feat_valid and layer_done: the write occurs first.
- FEED: lasts exactly 16 cycles (LANES*BEATS/FC_IN). Each cycle:
  - fc_en=1
  - fc_in element j = buf[rd_cnt*FC_IN+j]
  - rd_cnt++
  - first fc_en cycle is the first FEED cycle
  - after rd_cnt=15 -> WAIT_FC; fc_en=0 from the next cycle
  - no gaps, no backpressure
- fc_done outside WAIT_FC is ignored.
- WAIT_FC:
  - fc_done=1 -> capture fc_class, go to RESULT
  - tmo counter reaches FC_TIMEOUT -> IDLE with error=1, result unchanged
- RESULT, one cycle:
  - result_valid=1
  - result_class and seg updated with the captured value
  - -> IDLE
- start while busy is ignored, with no side effect.
- Reset mid-operation returns to IDLE immediately. fc_en and conv_start drop asynchronously; no partial result is emitted.
- Counter widths: wr_cnt 3b, rd_cnt 4b (wrap not reachable), tmo 10b, clog2(FC_TIMEOUT+1).

Decomposition:
- Package cnn_pkg:
  - fc_seq_state_t enum (IDLE, COLLECT, FEED, WAIT_FC, RESULT)
  - FEAT_W, LANES, BEATS, FC_IN constants
  - feat_t (signed [FEAT_W-1:0])
  - class_t (2b)
- One sub-module, feat_buffer: 64xFEAT_W register file with a LANES-wide write port (row index) and an FC_IN-wide read port (group index). It is written only by the sequencer.

Test Plan:
- Nominal:
  - stimulus: start; feat_valid x4 with byte value = beat*16+lane; layer_done; fc_done with fc_class=1 five cycles after the last fc_en
  - response: conv_start 1 cycle; fc_en high 16 consecutive cycles; fc_in beat n = {4n+3,4n+2,4n+1,4n}; result_valid pulse; seg=8'h01; error=0
- Early layer_done:
  - stimulus: layer_done after 3 beats
  - response: back to IDLE, error=1, fc_en never asserted; a following start clears error
- Overflow:
  - stimulus: 5 feat_valid beats before layer_done
  - response: error=1; buffer holds beats 0-3 only (check via fc_in)
- Timeout:
  - stimulus: no fc_done
  - response: IDLE after exactly FC_TIMEOUT WAIT_FC cycles; error=1; result_valid never pulses; seg holds previous value
- Collisions:
  - stimulus: feat_valid and layer_done in the same cycle on beat 4
  - response: proceeds to FEED
  - stimulus: start during FEED
  - response: ignored
  - stimulus: fc_done during FEED
  - response: ignored
- Reset:
  - stimulus: rst asserted mid-FEED
  - response: fc_en=0 immediately; busy=0; a subsequent full run gives the correct result
